// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scan controller: double-buffered BCD digits,
// one-hot digit enables, programmable dwell and inter-digit blanking.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [2:0]              digit_index,
    output logic                    frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // With no blank gap every digit boundary goes straight to the lit phase.
    localparam state_t FIRST_PHASE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_t                  state, state_nxt;
    logic [2:0]              idx, idx_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [4*NUM_DIGITS-1:0] pending, pending_nxt;
    logic [4*NUM_DIGITS-1:0] active, active_nxt;
    logic [4*NUM_DIGITS-1:0] frame_src;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic                    done_nxt;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        case (code)
            4'd0:    return 7'h7E;
            4'd1:    return 7'h30;
            4'd2:    return 7'h6D;
            4'd3:    return 7'h79;
            4'd4:    return 7'h33;
            4'd5:    return 7'h5B;
            4'd6:    return 7'h5F;
            4'd7:    return 7'h70;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        active_nxt  = active;
        done_nxt    = 1'b0;
        pending_nxt = load ? digits_in : pending;
        // A load landing on a frame boundary bypasses the pending register.
        frame_src   = load ? digits_in : pending;

        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    active_nxt = frame_src;
                    state_nxt  = FIRST_PHASE;
                    idx_nxt    = 3'd0;
                    cnt_nxt    = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = SHOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_nxt = FIRST_PHASE;
                        cnt_nxt   = '0;
                        if (idx == LAST_IDX) begin
                            idx_nxt    = 3'd0;
                            done_nxt   = 1'b1;
                            active_nxt = frame_src;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = 3'd0;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so the pins are registered.
        seg_nxt = 7'h00;
        an_nxt  = '0;
        if (state_nxt == SHOW) begin
            an_nxt = NUM_DIGITS'(1) << idx_nxt;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_nxt == 3'(k)) begin
                    seg_nxt = bcd_to_seg(active_nxt[4*k +: 4]);
                end
            end
        end
    end

    // Register stage: scan state, digit buffers and output pins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= '0;
            pending    <= '0;
            active     <= '0;
            seg        <= 7'h00;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            active     <= active_nxt;
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_done <= done_nxt;
        end
    end

    assign digit_index = idx;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (4 digits, 4-cycle dwell, 1 blank cycle):
// a frame-position model pushes expected pins per cycle, each test pops and compares.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = ND * (RD + BC);

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [2:0]  digit_index;
    logic        frame_done;

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .seg        (seg),
        .an         (an),
        .digit_index(digit_index),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Expected pins packed as {seg, an, digit_index, frame_done}.
    logic [14:0] sb[$];
    logic [14:0] got;
    logic [14:0] exp_v;

    logic        m_run  = 1'b0;
    int          m_pos  = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_pend = 16'h0;
    logic [15:0] m_act  = 16'h0;

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        logic [6:0] tbl [0:15];
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        return tbl[c];
    endfunction

    // Drive one cycle of inputs, advance the model, push its expectation, clock once.
    task automatic drive(input logic e, input logic l, input logic [15:0] d);
        logic [15:0] src;
        int          dg;
        int          ph;
        logic [6:0]  es;
        logic [3:0]  ea;
        logic [2:0]  ei;
        @(negedge clock);
        enable    = e;
        load      = l;
        digits_in = d;
        src = l ? d : m_pend;
        m_done = 1'b0;
        if (!e) begin
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_pos = 0;
            m_act = src;
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos  = 0;
                m_done = 1'b1;
                m_act  = src;
            end
        end
        if (l) m_pend = d;
        es = 7'h00;
        ea = 4'h0;
        ei = 3'd0;
        if (m_run) begin
            dg = m_pos / (RD + BC);
            ph = m_pos % (RD + BC);
            ei = 3'(dg);
            if (ph >= BC) begin
                ea = 4'(1 << dg);
                es = ref_seg(m_act[4*dg +: 4]);
            end
        end
        sb.push_back({es, ea, ei, m_done});
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #11;
        compared++;
        if ({seg, an, digit_index, frame_done} !== 15'h0) begin
            mismatched++;
            $display("FAIL reset_state: got %h required 0", {seg, an, digit_index, frame_done});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_scan();
        drive(1'b0, 1'b1, 16'h4321);
        got = {seg, an, digit_index, frame_done};
        exp_v = sb.pop_front();
        compared++;
        if (got !== exp_v) begin
            mismatched++;
            $display("FAIL scan_idle_load: got %h required %h", got, exp_v);
        end
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            drive(1'b1, 1'b0, 16'h0);
            got = {seg, an, digit_index, frame_done};
            exp_v = sb.pop_front();
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("FAIL scan cyc %0d: got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_decode();
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 1'b1, {12'h000, 4'(c)});
            for (int i = 0; i < 6; i++) begin
                if (i > 0) drive(1'b1, 1'b0, 16'h0);
                got = {seg, an, digit_index, frame_done};
                exp_v = sb.pop_front();
                compared++;
                if (got !== exp_v) begin
                    mismatched++;
                    $display("FAIL decode code %0d cyc %0d: got %h required %h", c, i, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_midframe_load();
        drive(1'b0, 1'b1, 16'h4321);
        void'(sb.pop_front());
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            drive(1'b1, (m_run && m_pos == 6), 16'h9999);
            got = {seg, an, digit_index, frame_done};
            exp_v = sb.pop_front();
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("FAIL midframe_load cyc %0d: got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_wrap_load();
        for (int i = 0; i < 2 * FRAME; i++) begin
            drive(1'b1, (m_run && m_pos == FRAME - 1 && i < FRAME), 16'h5678);
            got = {seg, an, digit_index, frame_done};
            exp_v = sb.pop_front();
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("FAIL wrap_load cyc %0d: got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic e;
        for (int i = 0; i < FRAME + 14; i++) begin
            e = !(m_run && m_pos == 12);
            if (!m_run && i > 0) e = 1'b1;
            drive(e, 1'b0, 16'h0);
            got = {seg, an, digit_index, frame_done};
            exp_v = sb.pop_front();
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("FAIL enable_drop cyc %0d: got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 16'h0);
            void'(sb.pop_front());
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({seg, an, frame_done} !== 12'h0) begin
            mismatched++;
            $display("FAIL async_reset_dark: got seg=%h an=%h done=%b required 0", seg, an, frame_done);
        end
        m_run  = 1'b0;
        m_pos  = 0;
        m_done = 1'b0;
        m_pend = 16'h0;
        m_act  = 16'h0;
        @(negedge clock);
        enable = 1'b0;
        load   = 1'b0;
        reset  = 1'b0;
        for (int i = 0; i < FRAME + 3; i++) begin
            drive(1'b1, 1'b0, 16'h0);
            got = {seg, an, digit_index, frame_done};
            exp_v = sb.pop_front();
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("FAIL after_reset cyc %0d: got %h required %h", i, got, exp_v);
            end
        end
        compared++;
        if (seg !== 7'h7E) begin
            mismatched++;
            $display("FAIL after_reset_zero_digit: got seg=%h required 7e", seg);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_midframe_load();
        test_wrap_load();
        test_enable_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed scan controller for a common-segment seven-segment display bank. It holds one 4-bit BCD code per digit and drives a single shared segment bus. It also drives one-hot digit enables so each digit is lit in turn for a programmable dwell, with a blanking gap between digits to suppress ghosting. It contains the full BCD-to-segment decode (all of a–g, not only e) and sits between the counter/datapath that produces the digit values and the display pins.

## Interface
- NUM_DIGITS, 4: digits scanned; legal 1..8.
- REFRESH_DIV, 1000: cycles each digit is lit; legal ≥1.
- BLANK_CYCLES, 2: cycles all digits are dark before each digit is lit; legal ≥0 (0 = no blank phase).
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  scanning runs while high.
- load  input  1  capture digits_in into the pending register this cycle.
- digits_in  input  4*NUM_DIGITS  BCD codes; digit k = digits_in[4k+3:4k].
- seg  output  7  {a,b,c,d,e,f,g}, active-high.
- an  output  NUM_DIGITS  one-hot digit enable, active-high.
- digit_index  output  3  index of digit currently scanned.
- frame_done  output  1  one-cycle pulse at end of a full scan.

## Operation
- Registers: pending[4*NUM_DIGITS] (written by load), active[4*NUM_DIGITS] (displayed), state, index, dwell counter.
- States: IDLE, BLANK, SHOW.
- IDLE: seg=0, an=0, index=0. enable=1 → active<=pending, go BLANK (or SHOW if BLANK_CYCLES=0), counter cleared.
- BLANK: seg=0, an=0 for BLANK_CYCLES cycles, then SHOW.
- SHOW: an = one-hot(index), seg = decode(active digit[index]) for REFRESH_DIV cycles. Then:
  - index<NUM_DIGITS-1: index+1, go BLANK/SHOW.
  - index=NUM_DIGITS-1: index wraps to 0, frame_done=1 for one cycle, active<=pending, go BLANK/SHOW.
- Decode (hex seg): 0→7E, 1→30, 2→6D, 3→79, 4→33, 5→5B, 6→5F, 7→70, 8→7F, 9→7B, codes 10–15→00 (blank digit).
- load: pending<=digits_in. active updates only at frame boundaries (IDLE exit or wrap), never mid-frame, so no tearing.
- Simultaneous load and frame boundary: active takes digits_in directly (bypass), pending also updated.
- enable low in any state: next edge → IDLE, outputs dark, index=0, counter cleared; frame_done not pulsed. pending retained.
- reset: asynchronous; state=IDLE, index=0, counter=0, pending=0, active=0, seg=0, an=0, digit_index=0, frame_done=0. Mid-scan reset blanks outputs immediately.

## Timing
- All outputs registered; no combinational input-to-output path.
- enable rise at edge N → BLANK visible after edge N+1; first digit lit after edge N+1+BLANK_CYCLES.
- Digit period = BLANK_CYCLES + REFRESH_DIV cycles; frame = NUM_DIGITS × digit period.
- frame_done asserted in the first cycle of the next frame's first phase (the cycle after last SHOW cycle).
- load → visible on segments at earliest at the next frame boundary; load during IDLE is visible at enable.
- an never has more than one bit set; an=0 whenever seg=0 by blanking.

## Test plan
- Params 4/4/1, digits_in=16'h4321 loaded, enable=1 → repeating 5-cycle pattern per digit: 1 blank, 4 cycles an=0001 seg=30; then an=0010 seg=6D; an=0100 seg=79; an=1000 seg=33; frame_done pulses every 20 cycles.
- All codes 0–15 on digit 0 → seg values match decode list; 10–15 give seg=00 with an=0001.
- load 16'h9999 mid-frame (digit 1 showing) → digits 1–3 still show old values; 9s (seg=7B) appear from next frame's digit 0.
- load coincident with wrap cycle → new value shown in the very next frame, not one frame later.
- enable dropped during SHOW of digit 2 → next cycle seg=00, an=0, index=0; re-enable restarts at digit 0 after 1 blank cycle.
- reset asserted asynchronously mid-SHOW (between edges) → seg, an, frame_done go 0 without waiting for clock; pending/active cleared; after release with enable=1, digits show seg=7E (code 0).
